spi_slave: RTL and testbench

- SPI slave front end that drives the single-port RAM's command interface and returns read data serially.
- Deserialises MOSI frames into 10-bit RAM commands (rx_data/rx_valid).
- On a read-data command, waits for the RAM's tx_valid, captures tx_data and serialises it onto MISO.
- Sits between the external SPI master pins and the RAM inside the wrapper; system clock domain, SPI bit rate = one bit per clk while SS_n is low.

---
 rtl/spi_pkg.sv | 21 ++
 rtl/spi_slave_if.sv | 14 +
 rtl/spi_tx_serializer.sv | 57 +++++
 rtl/spi_slave.sv | 118 +++++++++++
 tb/tb_spi_slave.sv | 224 ++++++++++++++++++++++
 5 files changed

// File: rtl/spi_pkg.sv
// Shared types and constants for the SPI slave front end.
package spi_pkg;

    localparam int SPI_DATA_WIDTH = 8;
    localparam int CMD_WIDTH      = SPI_DATA_WIDTH + 2;

    // Command field, word bits [9:8]
    localparam logic [1:0] CMD_WR_ADDR = 2'b00;
    localparam logic [1:0] CMD_WR_DATA = 2'b01;
    localparam logic [1:0] CMD_RD_ADDR = 2'b10;
    localparam logic [1:0] CMD_RD_DATA = 2'b11;

    typedef enum logic [2:0] {
        IDLE      = 3'd0,
        CHK_CMD   = 3'd1,
        WRITE     = 3'd2,
        READ_ADD  = 3'd3,
        READ_DATA = 3'd4
    } spi_state_e;

endpackage

// File: rtl/spi_slave_if.sv
// RAM-side command/readback bus between the SPI slave and the single-port RAM.
interface spi_slave_if #(parameter int DATA_WIDTH = 8);

    logic [DATA_WIDTH+1:0] rx_data;
    logic                  rx_valid;
    logic [DATA_WIDTH-1:0] tx_data;
    logic                  tx_valid;

    // SPI slave drives commands and consumes read data
    modport slave (output rx_data, rx_valid, input tx_data, tx_valid);
    // RAM consumes commands and returns read data
    modport master (input rx_data, rx_valid, output tx_data, tx_valid);

endinterface

// File: rtl/spi_tx_serializer.sv
// Shifts one captured RAM read word out on MISO, MSB first, one bit per clk.
module spi_tx_serializer #(
    parameter int DATA_WIDTH = 8
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  load,
    input  logic [DATA_WIDTH-1:0] data,
    input  logic                  SS_n,
    output logic                  MISO,
    output logic                  done
);

    localparam int CNT_W = (DATA_WIDTH > 1) ? $clog2(DATA_WIDTH) : 1;
    localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(DATA_WIDTH - 1);

    logic [DATA_WIDTH-1:0] shift_reg;
    logic [CNT_W-1:0]      cnt_reg;
    logic                  active_reg;
    logic                  finishing_reg;

    // finishing marks the cycle after the last bit, when MISO returns low
    assign done = finishing_reg;

    // Load, shift and drain; a load while busy is ignored so the word is never overwritten
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            shift_reg     <= '0;
            cnt_reg       <= '0;
            active_reg    <= 1'b0;
            finishing_reg <= 1'b0;
            MISO          <= 1'b0;
        end else if (SS_n) begin
            shift_reg     <= '0;
            cnt_reg       <= '0;
            active_reg    <= 1'b0;
            finishing_reg <= 1'b0;
            MISO          <= 1'b0;
        end else if (active_reg) begin
            MISO      <= shift_reg[DATA_WIDTH-1];
            shift_reg <= {shift_reg[DATA_WIDTH-2:0], 1'b0};
            cnt_reg   <= cnt_reg + CNT_W'(1);
            if (cnt_reg == LAST_BIT) begin
                active_reg    <= 1'b0;
                finishing_reg <= 1'b1;
            end
        end else if (finishing_reg) begin
            MISO          <= 1'b0;
            finishing_reg <= 1'b0;
        end else if (load) begin
            shift_reg  <= data;
            cnt_reg    <= '0;
            active_reg <= 1'b1;
        end
    end

endmodule

// File: rtl/spi_slave.sv
// SPI slave: deserialises MOSI into RAM command words and returns read data on MISO.
module spi_slave
    import spi_pkg::*;
#(
    parameter int DATA_WIDTH = SPI_DATA_WIDTH
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       SS_n,
    input  logic       MOSI,
    output logic       MISO,
    spi_slave_if.slave ram
);

    localparam int CW    = DATA_WIDTH + 2;
    localparam int CNT_W = $clog2(CW + 1);
    localparam logic [CNT_W-1:0] LAST_IDX = CNT_W'(CW - 1);
    localparam logic [CNT_W-1:0] FULL     = CNT_W'(CW);

    spi_state_e       state_reg, state_next;
    logic [CNT_W-1:0] bit_cnt_reg, bit_cnt_next;
    logic [CW-2:0]    shift_reg, shift_next;
    logic [CW-1:0]    rx_data_reg, rx_data_next;
    logic             rx_valid_reg, rx_valid_next;
    logic             rd_addr_seen_reg, rd_addr_seen_next;
    logic             tx_started_reg, tx_started_next;
    logic             tx_load;
    logic             tx_done;

    assign ram.rx_data  = rx_data_reg;
    assign ram.rx_valid = rx_valid_reg;

    // State and datapath registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg        <= IDLE;
            bit_cnt_reg      <= '0;
            shift_reg        <= '0;
            rx_data_reg      <= '0;
            rx_valid_reg     <= 1'b0;
            rd_addr_seen_reg <= 1'b0;
            tx_started_reg   <= 1'b0;
        end else begin
            state_reg        <= state_next;
            bit_cnt_reg      <= bit_cnt_next;
            shift_reg        <= shift_next;
            rx_data_reg      <= rx_data_next;
            rx_valid_reg     <= rx_valid_next;
            rd_addr_seen_reg <= rd_addr_seen_next;
            tx_started_reg   <= tx_started_next;
        end
    end

    // Next-state, deserialiser and readback control; SS_n high always aborts to IDLE
    always_comb begin
        state_next        = state_reg;
        bit_cnt_next      = bit_cnt_reg;
        shift_next        = shift_reg;
        rx_data_next      = rx_data_reg;
        rx_valid_next     = 1'b0;
        rd_addr_seen_next = rd_addr_seen_reg;
        tx_started_next   = tx_started_reg;
        tx_load           = 1'b0;
        case (state_reg)
            IDLE: begin
                bit_cnt_next    = '0;
                tx_started_next = 1'b0;
                if (!SS_n) state_next = CHK_CMD;
            end
            CHK_CMD: begin
                if (SS_n) begin
                    state_next   = IDLE;
                    bit_cnt_next = '0;
                end else begin
                    shift_next   = {{(CW-2){1'b0}}, MOSI};
                    bit_cnt_next = CNT_W'(1);
                    if (!MOSI)                 state_next = WRITE;
                    else if (rd_addr_seen_reg) state_next = READ_DATA;
                    else                       state_next = READ_ADD;
                end
            end
            WRITE, READ_ADD, READ_DATA: begin
                if (SS_n) begin
                    state_next      = IDLE;
                    bit_cnt_next    = '0;
                    tx_started_next = 1'b0;
                end else if (bit_cnt_reg < FULL) begin
                    // Counter saturates at FULL so the frame cannot restart a word
                    shift_next   = {shift_reg[CW-3:0], MOSI};
                    bit_cnt_next = bit_cnt_reg + CNT_W'(1);
                    if (bit_cnt_reg == LAST_IDX) begin
                        rx_data_next  = {shift_reg, MOSI};
                        rx_valid_next = 1'b1;
                        if (state_reg == READ_ADD) rd_addr_seen_next = 1'b1;
                    end
                end else if (state_reg == READ_DATA) begin
                    if (!tx_started_reg && ram.tx_valid) begin
                        tx_load         = 1'b1;
                        tx_started_next = 1'b1;
                    end
                    if (tx_done) rd_addr_seen_next = 1'b0;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    spi_tx_serializer #(.DATA_WIDTH(DATA_WIDTH)) u_tx (
        .clk   (clk),
        .rst_n (rst_n),
        .load  (tx_load),
        .data  (ram.tx_data),
        .SS_n  (SS_n),
        .MISO  (MISO),
        .done  (tx_done)
    );

endmodule

// File: tb/tb_spi_slave.sv
// Scoreboard bench for spi_slave: stimulus queues expected words/MISO bits, a monitor checks them.
module tb_spi_slave;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    logic SS_n = 1'b1;
    logic MOSI = 1'b0;
    wire  MISO;

    int checks = 0;
    int errors = 0;

    logic [9:0] rx_q[$];
    logic       miso_q[$];
    logic [9:0] mon_word;
    logic       mon_bit;

    spi_slave_if #(.DATA_WIDTH(8)) ram_if();

    spi_slave #(.DATA_WIDTH(8)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .SS_n  (SS_n),
        .MOSI  (MOSI),
        .MISO  (MISO),
        .ram   (ram_if.slave)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h, required %0h", name, act, exp);
        end
    endtask

    // Monitor: one sample per cycle, 1 time unit after the rising edge
    always begin
        @(posedge clk);
        #1;
        if (ram_if.rx_valid === 1'b1) begin
            if (rx_q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL rx_unexpected: got strobe with %0h, required none", ram_if.rx_data);
            end else begin
                mon_word = rx_q.pop_front();
                check("rx_data", 32'(ram_if.rx_data), 32'(mon_word));
                $display("rx word %03h expected %03h at %0t", ram_if.rx_data, mon_word, $time);
            end
        end
        if (miso_q.size() > 0) begin
            mon_bit = miso_q.pop_front();
            check("miso_bit", 32'(MISO), 32'(mon_bit));
        end else begin
            check("miso_idle", 32'(MISO), 32'd0);
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog: got no end of stimulus, required finish before timeout");
        $fatal(1);
    end

    task automatic idle(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic start_frame();
        @(negedge clk);
        SS_n = 1'b0;
        MOSI = 1'b0;
    endtask

    // Present the top n bits of w, MSB first; optional spurious tx_valid at bit index spur_at
    task automatic shift_bits(input logic [9:0] w, input int n, input int spur_at);
        for (int i = 9; i > 9 - n; i--) begin
            @(negedge clk);
            MOSI = w[i];
            if (i == spur_at) begin
                ram_if.tx_valid = 1'b1;
                ram_if.tx_data  = 8'hFF;
            end else begin
                ram_if.tx_valid = 1'b0;
            end
        end
    endtask

    task automatic send_word(input logic [9:0] w);
        start_frame();
        rx_q.push_back(w);
        shift_bits(w, 10, -1);
    endtask

    task automatic end_frame();
        @(negedge clk);
        SS_n = 1'b1;
        MOSI = 1'b0;
        ram_if.tx_valid = 1'b0;
        idle(2);
    endtask

    // One-cycle tx_valid; when a capture is expected, queue the MISO sequence that follows it
    task automatic tx_pulse(input logic [7:0] d, input bit expect_serial);
        @(negedge clk);
        ram_if.tx_valid = 1'b1;
        ram_if.tx_data  = d;
        if (expect_serial) begin
            miso_q.push_back(1'b0);
            for (int i = 7; i >= 0; i--) miso_q.push_back(d[i]);
            miso_q.push_back(1'b0);
        end
        @(negedge clk);
        ram_if.tx_valid = 1'b0;
    endtask

    initial begin
        ram_if.tx_valid = 1'b0;
        ram_if.tx_data  = 8'h00;
        #20;
        check("reset_miso", 32'(MISO), 32'd0);
        check("reset_rx_valid", 32'(ram_if.rx_valid), 32'd0);
        check("reset_rx_data", 32'(ram_if.rx_data), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        idle(2);

        // Write address, then MOSI noise after the word must give no further strobes
        send_word(10'h0A5);
        for (int i = 0; i < 12; i++) begin
            @(negedge clk);
            MOSI = i[0];
        end
        end_frame();
        check("rx_data_hold", 32'(ram_if.rx_data), 32'h0A5);

        // Asynchronous reset in the middle of a write frame
        start_frame();
        shift_bits(10'h0A5, 5, -1);
        #2;
        rst_n = 1'b0;
        #1;
        check("midreset_miso", 32'(MISO), 32'd0);
        check("midreset_rx_valid", 32'(ram_if.rx_valid), 32'd0);
        check("midreset_rx_data", 32'(ram_if.rx_data), 32'd0);
        @(negedge clk);
        SS_n = 1'b1;
        MOSI = 1'b0;
        idle(2);
        rst_n = 1'b1;
        idle(2);

        // Read address after reset: READ_ADD, tx_valid there is ignored
        send_word(10'h203);
        tx_pulse(8'h99, 1'b0);
        end_frame();

        // Read data: capture C3, second tx_valid during shifting ignored
        send_word(10'h35A);
        idle(1);
        tx_pulse(8'hC3, 1'b1);
        idle(2);
        tx_pulse(8'hFF, 1'b0);
        idle(10);
        end_frame();

        // rd_addr_seen cleared by the completed readback: next 1-frame is READ_ADD
        send_word(10'h301);
        tx_pulse(8'hAA, 1'b0);
        idle(4);
        end_frame();

        // READ_DATA abort after its word keeps rd_addr_seen set
        send_word(10'h3C0);
        idle(3);
        end_frame();
        send_word(10'h3C1);
        tx_pulse(8'h81, 1'b1);
        idle(12);
        end_frame();

        // Abort a write-data frame after 6 bits, then a full one
        start_frame();
        shift_bits(10'h1F0, 6, -1);
        end_frame();
        send_word(10'h1F0);
        end_frame();

        // Spurious tx_valid during and after a WRITE word
        start_frame();
        rx_q.push_back(10'h13C);
        shift_bits(10'h13C, 10, 5);
        tx_pulse(8'hFF, 1'b0);
        idle(3);
        end_frame();

        // SS_n rises on the edge that would sample bit 0
        start_frame();
        shift_bits(10'h0FF, 9, -1);
        end_frame();
        check("abort_bit0_rx_data", 32'(ram_if.rx_data), 32'h13C);

        // rd_addr_seen is 0 here: READ_ADD then READ_DATA
        send_word(10'h302);
        tx_pulse(8'h5A, 1'b0);
        end_frame();
        send_word(10'h303);
        idle(2);
        tx_pulse(8'h5A, 1'b1);
        idle(12);
        end_frame();
        check("final_rx_data", 32'(ram_if.rx_data), 32'h303);

        idle(3);
        check("rx_queue_drained", 32'(rx_q.size()), 32'd0);
        check("miso_queue_drained", 32'(miso_q.size()), 32'd0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
